// File: rtl/pipe_out_arbiter.sv
// pipe_out_arbiter: round-robin sharing of one block-throttled pipe-out endpoint among N_SRC sources.
// Optional PIPE_OUT_ARB_HEADER_EN prepends a per-source sequenced header word to every block.
module pipe_out_arbiter #(
    parameter int N_SRC       = 4,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_enable,
    input  logic [N_SRC-1:0]     src_ready,
    input  logic [32*N_SRC-1:0]  src_data,
    output logic [N_SRC-1:0]     src_read,
    input  logic                 pipe_out_read,
    input  logic                 pipe_out_blockstrobe,
    output logic                 pipe_out_ready,
    output logic [31:0]          pipe_out_data,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [31:0]          block_count,
    output logic                 protocol_error
);
    typedef enum logic [1:0] {IDLE, OFFER, XFER, DRAIN} state_t;
    localparam int CW = $clog2(BLOCK_WORDS + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      rr_q, rr_d, grant_q, grant_d, pick;
    logic [31:0]     bc_q, bc_d;
    logic            perr_q, perr_d, found, skip;
    logic [7:0]      req, rd;
    logic [31:0]     words [8];

    assign req = 8'(src_ready & src_enable);

    for (genvar g = 0; g < 8; g++) begin : g_w
        if (g < N_SRC) begin : g_on
            assign words[g] = src_data[32*g +: 32];
        end else begin : g_off
            assign words[g] = '0;
        end
    end

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            int j;
            j = (int'(rr_q) + k) % N_SRC;
            if (!found && req[3'(j)]) begin
                pick  = 3'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            bc_q    <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            bc_q    <= bc_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        bc_d    = bc_q;
        case (state_q)
            IDLE:  if (found) begin
                       grant_d = pick;
                       state_d = OFFER;
                   end
            // strobe has priority over a dropped request
            OFFER: if (pipe_out_blockstrobe) begin
                       state_d = XFER;
                       cnt_d   = '0;
                   end else if (!req[grant_q]) state_d = IDLE;
            XFER:  if (pipe_out_read) begin
                       cnt_d = cnt_q + 1'b1;
                       if (cnt_q == CW'(BLOCK_WORDS - 1)) state_d = DRAIN;
                   end
            DRAIN: begin
                       bc_d    = bc_q + 1'b1;
                       rr_d    = 3'((int'(grant_q) + 1) % N_SRC);
                       state_d = IDLE;
                   end
        endcase
        perr_d = perr_q | (pipe_out_read & (state_q == IDLE || state_q == OFFER))
                        | (pipe_out_blockstrobe & (state_q == XFER || state_q == DRAIN));
    end

`ifdef PIPE_OUT_ARB_HEADER_EN
    logic [15:0] seq_q [8];
    logic        hdr_q, hdr_d;
    assign skip  = cnt_q == '0;
    assign hdr_d = state_q == XFER && pipe_out_read && cnt_q == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q <= 1'b0;
            for (int k = 0; k < 8; k++) seq_q[k] <= '0;
        end else begin
            hdr_q <= hdr_d;
            if (state_q == DRAIN) seq_q[grant_q] <= seq_q[grant_q] + 1'b1;
        end
    end
    assign pipe_out_data = hdr_q ? {8'hA5, 5'b0, grant_q, seq_q[grant_q]} : words[grant_q];
`else
    assign skip          = 1'b0;
    assign pipe_out_data = words[grant_q];
`endif

    always_comb begin
        pipe_out_ready = state_q == OFFER;
        busy           = state_q != IDLE;
        rd             = (state_q == XFER && pipe_out_read && !reset && !skip) ? 8'd1 << grant_q : 8'd0;
        src_read       = rd[N_SRC-1:0];
    end

    assign grant_id       = grant_q;
    assign block_count    = bc_q;
    assign protocol_error = perr_q;
endmodule

// File: tb/tb_pipe_out_arbiter.sv
// tb_pipe_out_arbiter: randomized block traffic against a round-robin reference model.
// Sources are modelled as counters whose words encode (source, word index).
module tb_pipe_out_arbiter;
    localparam int N = 4, BW = 4;
`ifdef PIPE_OUT_ARB_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic            clk = 1'b0, reset = 1'b1;
    logic [N-1:0]    src_enable = '0, src_ready = '0, src_read;
    logic [32*N-1:0] src_data = '0;
    logic            pipe_out_read = 1'b0, pipe_out_blockstrobe = 1'b0;
    logic            pipe_out_ready, busy, protocol_error;
    logic [31:0]     pipe_out_data, block_count;
    logic [2:0]      grant_id;

    int passed = 0, total = 0;
    int nrd[N], exp_n[N], m_seq[N];
    int m_bc = 0, m_ptr = 0;
    bit m_perr = 1'b0;

    always #5 clk = ~clk;

    pipe_out_arbiter #(.N_SRC(N), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset(reset), .src_enable(src_enable), .src_ready(src_ready),
        .src_data(src_data), .src_read(src_read), .pipe_out_read(pipe_out_read),
        .pipe_out_blockstrobe(pipe_out_blockstrobe), .pipe_out_ready(pipe_out_ready),
        .pipe_out_data(pipe_out_data), .grant_id(grant_id), .busy(busy),
        .block_count(block_count), .protocol_error(protocol_error)
    );

    function automatic logic [31:0] mkword(int i, int n);
        return 32'h00C30000 | (32'(i) << 24) | 32'(n & 16'hFFFF);
    endfunction

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (src_read[i]) begin
                src_data[32*i +: 32] <= mkword(i, nrd[i]);
                nrd[i] <= nrd[i] + 1;
            end

    function automatic int next_g(int ptr, logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_bc = 0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_seq[i] = 0;
    endtask

    task automatic wait_offer;
        int t;
        t = 0;
        while (!pipe_out_ready && t < 20) begin
            tick();
            t++;
        end
        total++; if (pipe_out_ready !== 1'b1) $display("FAIL offer_wait: pipe_out_ready=%b want 1", pipe_out_ready); else passed++;
    endtask

    task automatic do_block(input int g, input bit clr_en);
        logic [31:0]  e;
        logic [N-1:0] er;
        wait_offer();
        total++; if (grant_id !== 3'(g)) $display("FAIL grant: grant_id=%0d want %0d", grant_id, g); else passed++;
        pipe_out_blockstrobe = 1'b1;
        tick();
        pipe_out_blockstrobe = 1'b0;
        total++; if ({pipe_out_ready, busy} !== 2'b01) $display("FAIL xfer_entry: ready,busy=%b want 01", {pipe_out_ready, busy}); else passed++;
        for (int w = 0; w < BW; w++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (clr_en && w == 2) src_enable = '0;
            pipe_out_read = 1'b1;
            @(negedge clk);
            er = (HDR && w == 0) ? '0 : N'(1) << g;
            total++; if (src_read !== er) $display("FAIL src_read w%0d: %b want %b", w, src_read, er); else passed++;
            tick();
            pipe_out_read = 1'b0;
            if (HDR && w == 0) e = {8'hA5, 5'b0, 3'(g), 16'(m_seq[g])};
            else begin
                e = mkword(g, exp_n[g]);
                exp_n[g]++;
            end
            total++; if (pipe_out_data !== e) $display("FAIL data w%0d: %h want %h", w, pipe_out_data, e); else passed++;
        end
        total++; if (busy !== 1'b1) $display("FAIL drain_busy: busy=%b want 1", busy); else passed++;
        m_bc++;
        m_ptr = (g + 1) % N;
        m_seq[g]++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL idle_busy: busy=%b want 0", busy); else passed++;
        total++; if (block_count !== 32'(m_bc)) $display("FAIL block_count: %0d want %0d", block_count, m_bc); else passed++;
        total++; if (protocol_error !== m_perr) $display("FAIL perr: %b want %b", protocol_error, m_perr); else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        total++; if ({pipe_out_ready, busy, protocol_error} !== 3'b000) $display("FAIL reset_flags: %b want 000", {pipe_out_ready, busy, protocol_error}); else passed++;
        total++; if (grant_id !== 3'd0) $display("FAIL reset_grant: %0d want 0", grant_id); else passed++;
        total++; if (block_count !== 32'd0) $display("FAIL reset_bc: %0d want 0", block_count); else passed++;
        total++; if (src_read !== '0) $display("FAIL reset_src_read: %b want 0", src_read); else passed++;
    endtask

    task automatic test_single;
        src_enable = '1;
        src_ready  = 4'b0001;
        do_block(next_g(m_ptr, src_ready & src_enable), 1'b0);
        src_ready = '0;
    endtask

    task automatic test_drop;
        src_ready = 4'b0100;
        wait_offer();
        total++; if (grant_id !== 3'd2) $display("FAIL drop_grant: %0d want 2", grant_id); else passed++;
        src_ready = '0;
        tick();
        total++; if ({pipe_out_ready, busy} !== 2'b00) $display("FAIL drop_idle: ready,busy=%b want 00", {pipe_out_ready, busy}); else passed++;
        src_ready = 4'b1100;
        do_block(next_g(m_ptr, src_ready & src_enable), 1'b0);
        src_ready = '0;
    endtask

    task automatic test_round_robin;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        src_ready = 4'b1010;
        repeat (4) do_block(next_g(m_ptr, src_ready & src_enable), 1'b0);
        src_ready = '0;
    endtask

    task automatic test_enable;
        src_enable = 4'b0001;
        src_ready  = 4'b1111;
        do_block(next_g(m_ptr, src_ready & src_enable), 1'b0);
        do_block(next_g(m_ptr, src_ready & src_enable), 1'b1);
        repeat (3) tick();
        total++; if (busy !== 1'b0) $display("FAIL enable_off_busy: busy=%b want 0", busy); else passed++;
        src_ready  = '0;
        src_enable = '1;
    endtask

    task automatic test_random;
        repeat (6) begin
            int r;
            src_enable = N'($urandom);
            src_ready  = N'($urandom);
            if ((src_enable & src_ready) == '0) begin
                r = $urandom_range(0, N - 1);
                src_enable[r] = 1'b1;
                src_ready[r]  = 1'b1;
            end
            do_block(next_g(m_ptr, src_ready & src_enable), 1'($urandom_range(0, 1)));
        end
        src_ready  = '0;
        src_enable = '1;
    endtask

    task automatic test_reset_mid;
        int g;
        src_ready = 4'b0001;
        g = next_g(m_ptr, src_ready & src_enable);
        wait_offer();
        pipe_out_blockstrobe = 1'b1;
        tick();
        pipe_out_blockstrobe = 1'b0;
        pipe_out_read = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        total++; if (src_read !== '0) $display("FAIL rst_src_read: %b want 0", src_read); else passed++;
        tick();
        reset = 1'b0;
        pipe_out_read = 1'b0;
        exp_n[g] += HDR ? 1 : 2;
        model_reset();
        total++; if ({pipe_out_ready, busy} !== 2'b00) $display("FAIL rst_state: ready,busy=%b want 00", {pipe_out_ready, busy}); else passed++;
        total++; if (block_count !== 32'd0 || grant_id !== 3'd0) $display("FAIL rst_regs: bc=%0d grant=%0d want 0 0", block_count, grant_id); else passed++;
        pipe_out_read = 1'b1;
        @(negedge clk);
        total++; if (src_read !== '0) $display("FAIL stray_src_read: %b want 0", src_read); else passed++;
        tick();
        pipe_out_read = 1'b0;
        m_perr = 1'b1;
        total++; if (protocol_error !== 1'b1) $display("FAIL stray_perr: %b want 1", protocol_error); else passed++;
        do_block(next_g(m_ptr, src_ready & src_enable), 1'b0);
        src_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_drop();
        test_round_robin();
        test_enable();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
